// File: rtl/mem_port_arbiter_pkg.sv
// Package: mem_port_arbiter_pkg
// Purpose : Shared definitions for the memory port arbiter: MCU op codes,
//           arbiter FSM state encoding, port-owner encoding and the
//           store-class helper used to decide whether a result is returned.
// Contents:
//   mem_op_e    - LDW/LDH/LDB/STB/STH/STW op codes (codes 6 and 7 undefined)
//   arb_state_e - ARB_IDLE / ARB_ACCESS / ARB_RESP
//   arb_owner_e - which port owns the current access (data or fetch)
//   is_store()  - true only for the three defined store op codes
package mem_port_arbiter_pkg;

  typedef enum logic [2:0] {
    OP_LDW = 3'd0,
    OP_LDH = 3'd1,
    OP_LDB = 3'd2,
    OP_STB = 3'd3,
    OP_STH = 3'd4,
    OP_STW = 3'd5
  } mem_op_e;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ACCESS = 2'd1,
    ARB_RESP   = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWNER_DATA  = 1'b0,
    OWNER_FETCH = 1'b1
  } arb_owner_e;

  // Undefined codes are deliberately not stores: the MCU reads a word for
  // them and the arbiter hands the result back as a load.
  function automatic logic is_store(input logic [2:0] op);
    return (op == OP_STB) || (op == OP_STH) || (op == OP_STW);
  endfunction

endpackage

// File: rtl/mem_arb_grant.sv
// Module : mem_arb_grant
// Purpose: Turns the fetch/data request pair into a one-hot (or zero) grant.
//          Default build: fixed priority, data wins over fetch.
//          With MEM_ARB_RR_EN defined: round-robin, the port named by rr_ptr
//          wins a tie. A lone requester is always granted.
// Ports  :
//   en      in  1  grants allowed this cycle (arbiter idle, not in reset)
//   if_req  in  1  fetch request
//   d_req   in  1  data request
//   rr_ptr  in  1  tie-break owner (only present with MEM_ARB_RR_EN)
//   if_gnt  out 1  fetch granted
//   d_gnt   out 1  data granted
module mem_arb_grant
  import mem_port_arbiter_pkg::*;
(
  input  logic       en,
  input  logic       if_req,
  input  logic       d_req,
`ifdef MEM_ARB_RR_EN
  input  arb_owner_e rr_ptr,
`endif
  output logic       if_gnt,
  output logic       d_gnt
);

  always_comb begin
    if_gnt = 1'b0;
    d_gnt  = 1'b0;
    if (en) begin
`ifdef MEM_ARB_RR_EN
      if (if_req && d_req) begin
        if (rr_ptr == OWNER_FETCH) begin
          if_gnt = 1'b1;
        end else begin
          d_gnt = 1'b1;
        end
      end else begin
        if_gnt = if_req;
        d_gnt  = d_req;
      end
`else
      d_gnt  = d_req;
      if_gnt = if_req && !d_req;
`endif
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Module : mem_port_arbiter
// Purpose: Shares the single combinational MCU between the instruction-fetch
//          port and the load/store data port. One request is accepted at a
//          time; the MCU is driven for 1+WAIT_CYCLES cycles, the result is
//          registered and a one-cycle rvalid pulse is returned to the owner.
//          mem_ctl[3] is low whenever no access is in flight.
// Config : MEM_ARB_RR_EN undefined -> fixed priority (data over fetch)
//          MEM_ARB_RR_EN defined   -> round-robin, pointer resets to data
// Params : WAIT_CYCLES extra ACCESS cycles; CNT_W wait counter width
// Ports  :
//   clk, rst                         clock, async active-high reset
//   if_req/if_addr -> if_gnt         fetch request (always LDW)
//   if_rvalid/if_rdata               fetch response
//   d_req/d_op/d_addr/d_wdata -> d_gnt  data request
//   d_rvalid/d_rdata                 data response (rdata 0 for stores)
//   mem_addr/mem_num/mem_ctl         to MCU, mem_ctl = {enable, op}
//   mem_out                          from MCU
//   busy                             arbiter not idle
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int WAIT_CYCLES = 0,
  parameter int CNT_W       = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic [2:0]  d_op,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_num,
  output logic [3:0]  mem_ctl,
  input  logic [31:0] mem_out,
  output logic        busy
);

  localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT_CYCLES);

  arb_state_e       state_q,    state_d;
  arb_owner_e       owner_q,    owner_d;
  logic [2:0]       op_q,       op_d;
  logic [CNT_W-1:0] cnt_q,      cnt_d;
  logic [31:0]      mem_addr_q, mem_addr_d;
  logic [31:0]      mem_num_q,  mem_num_d;
  logic [31:0]      if_rdata_q, if_rdata_d;
  logic [31:0]      d_rdata_q,  d_rdata_d;
  logic [31:0]      result;
  logic             arb_en;

`ifdef MEM_ARB_RR_EN
  arb_owner_e       rr_ptr_q,   rr_ptr_d;
`endif

  // Grants are gated by reset as well as state so that requests held high
  // during reset never appear granted.
  assign arb_en = (state_q == ARB_IDLE) && !rst;

  mem_arb_grant u_grant (
    .en     (arb_en),
    .if_req (if_req),
    .d_req  (d_req),
`ifdef MEM_ARB_RR_EN
    .rr_ptr (rr_ptr_q),
`endif
    .if_gnt (if_gnt),
    .d_gnt  (d_gnt)
  );

  // Stores return zero; everything else (including undefined ops) returns
  // whatever the MCU produced.
  assign result = is_store(op_q) ? 32'h0 : mem_out;

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    op_d       = op_q;
    cnt_d      = cnt_q;
    mem_addr_d = mem_addr_q;
    mem_num_d  = mem_num_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
`ifdef MEM_ARB_RR_EN
    rr_ptr_d   = rr_ptr_q;
`endif
    case (state_q)
      ARB_IDLE: begin
        if (d_gnt) begin
          state_d    = ARB_ACCESS;
          owner_d    = OWNER_DATA;
          op_d       = d_op;
          mem_addr_d = d_addr;
          mem_num_d  = d_wdata;
          cnt_d      = WAIT_LOAD;
`ifdef MEM_ARB_RR_EN
          rr_ptr_d   = OWNER_FETCH;
`endif
        end else if (if_gnt) begin
          state_d    = ARB_ACCESS;
          owner_d    = OWNER_FETCH;
          op_d       = OP_LDW;
          mem_addr_d = if_addr;
          mem_num_d  = 32'h0;
          cnt_d      = WAIT_LOAD;
`ifdef MEM_ARB_RR_EN
          rr_ptr_d   = OWNER_DATA;
`endif
        end
      end
      ARB_ACCESS: begin
        // The MCU is combinational, so its output is sampled on the last
        // cycle of the window rather than the first.
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          state_d = ARB_RESP;
          if (owner_q == OWNER_DATA) begin
            d_rdata_d = result;
          end else begin
            if_rdata_d = result;
          end
        end
      end
      ARB_RESP: begin
        state_d = ARB_IDLE;
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ARB_IDLE;
      owner_q    <= OWNER_DATA;
      op_q       <= 3'd0;
      cnt_q      <= '0;
      mem_addr_q <= 32'h0;
      mem_num_q  <= 32'h0;
      if_rdata_q <= 32'h0;
      d_rdata_q  <= 32'h0;
`ifdef MEM_ARB_RR_EN
      rr_ptr_q   <= OWNER_DATA;
`endif
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      op_q       <= op_d;
      cnt_q      <= cnt_d;
      mem_addr_q <= mem_addr_d;
      mem_num_q  <= mem_num_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
`ifdef MEM_ARB_RR_EN
      rr_ptr_q   <= rr_ptr_d;
`endif
    end
  end

  // mem_ctl decodes straight from the state flop, so an asynchronous reset
  // removes the enable in the same cycle.
  assign mem_ctl   = (state_q == ARB_ACCESS) ? {1'b1, op_q} : 4'b0000;
  assign if_rvalid = (state_q == ARB_RESP) && (owner_q == OWNER_FETCH);
  assign d_rvalid  = (state_q == ARB_RESP) && (owner_q == OWNER_DATA);
  assign busy      = (state_q != ARB_IDLE);
  assign mem_addr  = mem_addr_q;
  assign mem_num   = mem_num_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench: tb_mem_port_arbiter
// Purpose  : Exercises mem_port_arbiter with WAIT_CYCLES=0 (dut0) and
//            WAIT_CYCLES=3 (dut3), each attached to its own little-endian
//            MCU model. Honours MEM_ARB_RR_EN for the contention sequence.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // dut0 signals (WAIT_CYCLES = 0)
  logic        if_req, if_gnt, if_rvalid, d_req, d_gnt, d_rvalid, busy;
  logic [31:0] if_addr, if_rdata, d_addr, d_wdata, d_rdata;
  logic [31:0] mem_addr, mem_num, mem_out;
  logic [2:0]  d_op;
  logic [3:0]  mem_ctl;

  // dut3 signals (WAIT_CYCLES = 3)
  logic        if_req_w3, if_gnt_w3, if_rvalid_w3, d_req_w3, d_gnt_w3, d_rvalid_w3, busy_w3;
  logic [31:0] if_addr_w3, if_rdata_w3, d_addr_w3, d_wdata_w3, d_rdata_w3;
  logic [31:0] mem_addr_w3, mem_num_w3, mem_out_w3;
  logic [2:0]  d_op_w3;
  logic [3:0]  mem_ctl_w3;

  mem_port_arbiter #(.WAIT_CYCLES(0), .CNT_W(4)) dut0 (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_op(d_op), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_addr(mem_addr), .mem_num(mem_num), .mem_ctl(mem_ctl), .mem_out(mem_out), .busy(busy)
  );

  mem_port_arbiter #(.WAIT_CYCLES(3), .CNT_W(4)) dut3 (
    .clk(clk), .rst(rst),
    .if_req(if_req_w3), .if_addr(if_addr_w3), .if_gnt(if_gnt_w3), .if_rvalid(if_rvalid_w3), .if_rdata(if_rdata_w3),
    .d_req(d_req_w3), .d_op(d_op_w3), .d_addr(d_addr_w3), .d_wdata(d_wdata_w3),
    .d_gnt(d_gnt_w3), .d_rvalid(d_rvalid_w3), .d_rdata(d_rdata_w3),
    .mem_addr(mem_addr_w3), .mem_num(mem_num_w3), .mem_ctl(mem_ctl_w3), .mem_out(mem_out_w3), .busy(busy_w3)
  );

  // MCU models: combinational read, write on the clock edge while enabled.
  logic [31:0] mem0 [0:63] = '{0: 32'h00100133, default: 32'h0};
  logic [31:0] mem3 [0:63] = '{0: 32'h00100133, default: 32'h0};

  function automatic logic [31:0] mcu_read(input logic [31:0] word, input logic [31:0] addr,
                                           input logic [2:0] op);
    logic [31:0] sh;
    sh = word >> {addr[1:0], 3'b000};
    case (op)
      OP_LDH:  return {16'h0, sh[15:0]};
      OP_LDB:  return {24'h0, sh[7:0]};
      default: return word;
    endcase
  endfunction

  function automatic logic [31:0] mcu_merge(input logic [31:0] word, input logic [31:0] addr,
                                            input logic [2:0] op, input logic [31:0] data);
    logic [31:0] mask;
    logic [4:0]  sh;
    sh = {addr[1:0], 3'b000};
    case (op)
      OP_STB:  mask = 32'h000000FF << sh;
      OP_STH:  mask = 32'h0000FFFF << sh;
      default: begin mask = 32'hFFFFFFFF; sh = 5'd0; end
    endcase
    return (word & ~mask) | ((data << sh) & mask);
  endfunction

  function automatic logic tb_is_store(input logic [2:0] op);
    return (op == OP_STB) || (op == OP_STH) || (op == OP_STW);
  endfunction

  assign mem_out    = mem_ctl[3]    ? mcu_read(mem0[mem_addr[7:2]], mem_addr, mem_ctl[2:0]) : 32'h0;
  assign mem_out_w3 = mem_ctl_w3[3] ? mcu_read(mem3[mem_addr_w3[7:2]], mem_addr_w3, mem_ctl_w3[2:0]) : 32'h0;

  always @(posedge clk) begin
    if (mem_ctl[3] && tb_is_store(mem_ctl[2:0]))
      mem0[mem_addr[7:2]] <= mcu_merge(mem0[mem_addr[7:2]], mem_addr, mem_ctl[2:0], mem_num);
    if (mem_ctl_w3[3] && tb_is_store(mem_ctl_w3[2:0]))
      mem3[mem_addr_w3[7:2]] <= mcu_merge(mem3[mem_addr_w3[7:2]], mem_addr_w3, mem_ctl_w3[2:0], mem_num_w3);
  end

  typedef struct {
    logic        is_fetch;
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [11];

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    end
  endtask

  // One full transaction on dut0, checking grant, access cycle and response.
  task automatic apply_stimulus(input int idx, input vec_t v);
    int  waited;
    logic got;
    @(posedge clk); #1;
    if (v.is_fetch) begin
      if_req = 1'b1; if_addr = v.addr;
    end else begin
      d_req = 1'b1; d_op = v.op; d_addr = v.addr; d_wdata = v.wdata;
    end
    got = 1'b0;
    for (waited = 0; waited < 10 && !got; waited++) begin
      @(negedge clk);
      got = v.is_fetch ? if_gnt : d_gnt;
    end
    check_output($sformatf("v%0d_gnt_immediate", idx), 32'(waited), 32'd1);
    if (!got) begin
      if_req = 1'b0; d_req = 1'b0;
      return;
    end
    check_output($sformatf("v%0d_other_gnt", idx), 32'(v.is_fetch ? d_gnt : if_gnt), 32'd0);
    @(posedge clk); #1;
    if_req = 1'b0; d_req = 1'b0;
    @(negedge clk);
    check_output($sformatf("v%0d_mem_ctl", idx), 32'(mem_ctl), 32'({1'b1, (v.is_fetch ? 3'(OP_LDW) : v.op)}));
    check_output($sformatf("v%0d_mem_addr", idx), mem_addr, v.addr);
    if (!v.is_fetch && tb_is_store(v.op))
      check_output($sformatf("v%0d_mem_num", idx), mem_num, v.wdata);
    check_output($sformatf("v%0d_rvalid_early", idx), 32'({if_rvalid, d_rvalid}), 32'd0);
    @(negedge clk);
    check_output($sformatf("v%0d_rvalid", idx), 32'({if_rvalid, d_rvalid}), v.is_fetch ? 32'd2 : 32'd1);
    check_output($sformatf("v%0d_rdata", idx), v.is_fetch ? if_rdata : d_rdata, v.exp_rdata);
    check_output($sformatf("v%0d_resp_mem_ctl", idx), 32'(mem_ctl), 32'd0);
    @(negedge clk);
    check_output($sformatf("v%0d_rvalid_after", idx), 32'({if_rvalid, d_rvalid, busy}), 32'd0);
    check_output($sformatf("v%0d_addr_hold", idx), mem_addr, v.addr);
  endtask

  // Fetch of word 0 on dut3, checking the stretched access window.
  task automatic fetch_w3(input string tag);
    int en_cnt, rv_cnt, rv_cyc;
    @(posedge clk); #1;
    if_req_w3 = 1'b1; if_addr_w3 = 32'h0;
    @(negedge clk);
    check_output({tag, "_gnt"}, 32'(if_gnt_w3), 32'd1);
    @(posedge clk); #1;
    if_req_w3 = 1'b0;
    en_cnt = 0; rv_cnt = 0; rv_cyc = 0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (mem_ctl_w3[3]) en_cnt++;
      if (if_rvalid_w3) begin rv_cnt++; rv_cyc = k; end
      check_output($sformatf("%s_busy_c%0d", tag, k), 32'(busy_w3), (k <= 5) ? 32'd1 : 32'd0);
    end
    check_output({tag, "_enable_cycles"}, 32'(en_cnt), 32'd4);
    check_output({tag, "_rvalid_count"}, 32'(rv_cnt), 32'd1);
    check_output({tag, "_rvalid_cycle"}, 32'(rv_cyc), 32'd5);
    check_output({tag, "_rdata"}, if_rdata_w3, 32'h00100133);
  endtask

  initial begin
    logic [3:0] exp_fetch_seq;
    logic [3:0] got_fetch_seq;
    int         grants;
    int         rv_seen;
    logic       both;

    vecs[0]  = '{1'b1, OP_LDW, 32'h00, 32'h0,        32'h00100133};
    vecs[1]  = '{1'b0, OP_STW, 32'h3C, 32'h12345678, 32'h0};
    vecs[2]  = '{1'b0, OP_LDW, 32'h3C, 32'h0,        32'h12345678};
    vecs[3]  = '{1'b0, OP_LDB, 32'h3D, 32'h0,        32'h00000056};
    vecs[4]  = '{1'b0, OP_LDH, 32'h3E, 32'h0,        32'h00001234};
    vecs[5]  = '{1'b0, OP_STB, 32'h41, 32'h000000AB, 32'h0};
    vecs[6]  = '{1'b0, OP_LDW, 32'h40, 32'h0,        32'h0000AB00};
    vecs[7]  = '{1'b0, OP_STH, 32'h46, 32'h0000BEEF, 32'h0};
    vecs[8]  = '{1'b0, OP_LDW, 32'h44, 32'h0,        32'hBEEF0000};
    vecs[9]  = '{1'b0, 3'd7,   32'h3C, 32'h0,        32'h12345678};
    vecs[10] = '{1'b1, OP_LDW, 32'h3C, 32'h0,        32'h12345678};

    // Reset held with every request asserted.
    rst = 1'b1;
    if_req = 1'b1; if_addr = 32'h0; d_req = 1'b1; d_op = OP_STW; d_addr = 32'h3C; d_wdata = 32'hFFFFFFFF;
    if_req_w3 = 1'b1; if_addr_w3 = 32'h0; d_req_w3 = 1'b1; d_op_w3 = OP_STW; d_addr_w3 = 32'h0; d_wdata_w3 = 32'hFFFFFFFF;
    repeat (3) @(negedge clk);
    check_output("rst_gnt", 32'({if_gnt, d_gnt, if_gnt_w3, d_gnt_w3}), 32'd0);
    check_output("rst_rvalid", 32'({if_rvalid, d_rvalid, if_rvalid_w3, d_rvalid_w3}), 32'd0);
    check_output("rst_mem_ctl", 32'({mem_ctl, mem_ctl_w3}), 32'd0);
    check_output("rst_busy", 32'({busy, busy_w3}), 32'd0);
    check_output("rst_mem_addr", mem_addr | mem_addr_w3, 32'h0);
    check_output("rst_mem_num", mem_num | mem_num_w3, 32'h0);
    check_output("rst_rdata", if_rdata | d_rdata | if_rdata_w3 | d_rdata_w3, 32'h0);
    @(posedge clk); #1;
    if_req = 1'b0; d_req = 1'b0; if_req_w3 = 1'b0; d_req_w3 = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 11; i++) apply_stimulus(i, vecs[i]);

    fetch_w3("w3_fetch");

    // Fresh reset so the round-robin pointer starts at data.
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;

    // Contention: both ports hold their requests for four transactions.
`ifdef MEM_ARB_RR_EN
    exp_fetch_seq = 4'b1010;
`else
    exp_fetch_seq = 4'b0000;
`endif
    got_fetch_seq = 4'b0000;
    grants = 0;
    both = 1'b0;
    if_req = 1'b1; if_addr = 32'h0; d_req = 1'b1; d_op = OP_LDW; d_addr = 32'h3C;
    for (int c = 0; c < 40 && grants < 4; c++) begin
      @(negedge clk);
      if (if_gnt && d_gnt) both = 1'b1;
      if (d_gnt) begin
        grants++;
      end else if (if_gnt) begin
        got_fetch_seq[grants] = 1'b1;
        grants++;
      end
    end
    @(posedge clk); #1;
    if_req = 1'b0; d_req = 1'b0;
    check_output("cont_grants", 32'(grants), 32'd4);
    check_output("cont_double_gnt", 32'(both), 32'd0);
    check_output("cont_sequence", 32'(got_fetch_seq), 32'(exp_fetch_seq));
    repeat (3) @(negedge clk);
    check_output("cont_idle", 32'(busy), 32'd0);

    // Reset in the middle of a stretched LDW on dut3.
    @(posedge clk); #1;
    d_req_w3 = 1'b1; d_op_w3 = OP_LDW; d_addr_w3 = 32'h0;
    @(negedge clk);
    check_output("mid_gnt", 32'(d_gnt_w3), 32'd1);
    @(posedge clk); #1;
    d_req_w3 = 1'b0;
    @(negedge clk);
    check_output("mid_access_ctl", 32'(mem_ctl_w3), 32'h8);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_output("mid_rst_ctl", 32'(mem_ctl_w3), 32'd0);
    check_output("mid_rst_busy", 32'(busy_w3), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    rv_seen = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (d_rvalid_w3) rv_seen++;
    end
    check_output("mid_no_rvalid", 32'(rv_seen), 32'd0);
    check_output("mid_rdata_untouched", d_rdata_w3, 32'h0);
    fetch_w3("post_rst_fetch");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
